// File: rtl/ip_hash_pkg.sv
// Shared types and helpers for the IPv4 source-address hash table.
// The XOR-fold accepts addresses up to FOLD_MAX_W bits wide.
package ip_hash_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PROBE = 1'b1
  } state_t;

  typedef enum logic {
    OP_INSERT = 1'b0,
    OP_LOOKUP = 1'b1
  } op_t;

  localparam int FOLD_MAX_W = 128;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

  // Bits above the real address width are zero, so they drop out of the fold.
  function automatic logic [31:0] xor_fold(input logic [FOLD_MAX_W-1:0] addr,
                                           input int idx_w);
    logic [FOLD_MAX_W-1:0] rest;
    logic [31:0]           mask;
    logic [31:0]           res;
    rest = addr;
    res  = '0;
    mask = (32'd1 << idx_w) - 32'd1;
    for (int c = 0; c < FOLD_MAX_W; c += idx_w) begin
      res  = res ^ (rest[31:0] & mask);
      rest = rest >> idx_w;
    end
    return res;
  endfunction

endpackage

// File: rtl/ip_hash_fn.sv
// Combinational XOR-fold of an address into a table index.
module ip_hash_fn
  import ip_hash_pkg::*;
#(
  parameter int IP_ADDR_W = 32,
  parameter int IDX_W     = 6
) (
  input  logic [IP_ADDR_W-1:0] ip_addr,
  output logic [IDX_W-1:0]     hash
);

  assign hash = IDX_W'(xor_fold(FOLD_MAX_W'(ip_addr), IDX_W));

endmodule

// File: rtl/ip_hash_table.sv
// Open-addressed IPv4 address table with linear probing, one slot examined per clock.
// Supports insert, lookup and flush; results are registered and qualified by found_ip_valid.
module ip_hash_table
  import ip_hash_pkg::*;
#(
  parameter int IP_ADDR_W   = 32,
  parameter int TABLE_DEPTH = 64,
  parameter int MAX_PROBE   = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         insert_val,
  input  logic                         look_up_val,
  input  logic [IP_ADDR_W-1:0]         ip_addr,
  input  logic                         flush,
  output logic                         ready,
  output logic                         found_ip,
  output logic                         found_ip_valid,
  output logic                         insert_ok,
  output logic                         insert_fail,
  output logic [$clog2(TABLE_DEPTH):0] entry_count
);

  localparam int IDX_W = idx_width(TABLE_DEPTH);
  localparam int CNT_W = IDX_W + 1;
  localparam int P_W   = (MAX_PROBE > 1) ? $clog2(MAX_PROBE) : 1;

  state_t                 state;
  state_t                 state_nxt;
  op_t                    op;
  logic [P_W-1:0]         probe_idx;
  logic [IP_ADDR_W-1:0]   ip_reg;
  logic [IDX_W-1:0]       hash;
  logic [IDX_W-1:0]       slot;
  logic [TABLE_DEPTH-1:0] valid_bits;
  logic [IP_ADDR_W-1:0]   tags [TABLE_DEPTH];

  logic accept;
  logic flush_en;
  logic slot_valid;
  logic slot_hit;
  logic last_probe;
  logic done;
  logic write_en;
  logic nxt_found;
  logic nxt_valid;
  logic nxt_ok;
  logic nxt_fail;

  ip_hash_fn #(
    .IP_ADDR_W(IP_ADDR_W),
    .IDX_W    (IDX_W)
  ) u_hash (
    .ip_addr(ip_reg),
    .hash   (hash)
  );

  assign ready    = (state == IDLE);
  assign flush_en = ready && flush;
  assign accept   = ready && !flush && (insert_val || look_up_val);
  assign slot     = hash + IDX_W'(probe_idx);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = PROBE;
      PROBE:   if (done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Slot evaluation: a hit wins over everything, an empty slot ends the chain,
  // and only a full window of occupied mismatching slots ends in failure.
  always_comb begin
    slot_valid = valid_bits[slot];
    slot_hit   = slot_valid && (tags[slot] == ip_reg);
    last_probe = (probe_idx == P_W'(MAX_PROBE - 1));
    done       = 1'b0;
    write_en   = 1'b0;
    nxt_found  = 1'b0;
    nxt_valid  = 1'b0;
    nxt_ok     = 1'b0;
    nxt_fail   = 1'b0;
    if (state == PROBE) begin
      if (slot_hit) begin
        done      = 1'b1;
        nxt_valid = 1'b1;
        nxt_found = 1'b1;
      end else if (!slot_valid) begin
        done      = 1'b1;
        nxt_valid = 1'b1;
        if (op == OP_INSERT) begin
          write_en = 1'b1;
          nxt_ok   = 1'b1;
        end
      end else if (last_probe) begin
        done      = 1'b1;
        nxt_valid = 1'b1;
        nxt_fail  = (op == OP_INSERT);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      found_ip       <= 1'b0;
      found_ip_valid <= 1'b0;
      insert_ok      <= 1'b0;
      insert_fail    <= 1'b0;
    end else begin
      found_ip       <= nxt_found;
      found_ip_valid <= nxt_valid;
      insert_ok      <= nxt_ok;
      insert_fail    <= nxt_fail;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op        <= OP_INSERT;
      probe_idx <= '0;
      ip_reg    <= '0;
    end else if (accept) begin
      op        <= insert_val ? OP_INSERT : OP_LOOKUP;
      probe_idx <= '0;
      ip_reg    <= ip_addr;
    end else if (state == PROBE && !done) begin
      probe_idx <= probe_idx + P_W'(1);
    end
  end

  // Occupancy and count; a write only ever lands on an empty slot,
  // so the count cannot pass TABLE_DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_bits  <= '0;
      entry_count <= '0;
    end else if (flush_en) begin
      valid_bits  <= '0;
      entry_count <= '0;
    end else if (write_en) begin
      valid_bits[slot] <= 1'b1;
      entry_count      <= entry_count + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) begin
      tags[slot] <= ip_reg;
    end
  end

endmodule

// File: tb/tb_ip_hash_table.sv
// Bench for ip_hash_table: directed scenarios plus randomized traffic,
// checked against a slot-array model of the probing rules.
module tb_ip_hash_table;

  localparam int DEPTH     = 64;
  localparam int MAX_PROBE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insert_val = 1'b0;
  logic        look_up_val = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] ip_addr = '0;
  logic        ready;
  logic        found_ip;
  logic        found_ip_valid;
  logic        insert_ok;
  logic        insert_fail;
  logic [6:0]  entry_count;

  int checks = 0;
  int errors = 0;

  bit          m_valid [DEPTH];
  logic [31:0] m_tag [DEPTH];
  int          m_count;

  logic [31:0] wrap_addr [5];

  ip_hash_table #(
    .IP_ADDR_W  (32),
    .TABLE_DEPTH(DEPTH),
    .MAX_PROBE  (MAX_PROBE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .insert_val    (insert_val),
    .look_up_val   (look_up_val),
    .ip_addr       (ip_addr),
    .flush         (flush),
    .ready         (ready),
    .found_ip      (found_ip),
    .found_ip_valid(found_ip_valid),
    .insert_ok     (insert_ok),
    .insert_fail   (insert_fail),
    .entry_count   (entry_count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int model_hash(input logic [31:0] a);
    int     h;
    longint v;
    h = 0;
    v = longint'(a);
    while (v != 0) begin
      h = h ^ int'(v % DEPTH);
      v = v / DEPTH;
    end
    return h;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic model_op(input bit ins, input logic [31:0] a,
                          output bit f, output bit ok, output bit fl, output int probes);
    int  h;
    int  s;
    bit  decided;
    h = model_hash(a);
    f = 1'b0; ok = 1'b0; fl = 1'b0; probes = MAX_PROBE; decided = 1'b0;
    for (int p = 0; p < MAX_PROBE && !decided; p++) begin
      s = (h + p) % DEPTH;
      if (m_valid[s] && m_tag[s] == a) begin
        f = 1'b1; probes = p + 1; decided = 1'b1;
      end else if (!m_valid[s]) begin
        if (ins) begin
          m_valid[s] = 1'b1; m_tag[s] = a; m_count++; ok = 1'b1;
        end
        probes = p + 1; decided = 1'b1;
      end
    end
    if (!decided) fl = ins;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (!ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready) checkOutput("ready_wait", 32'(ready), 1);
  endtask

  task automatic applyStimulus(input bit ins, input bit look, input logic [31:0] addr);
    bit ef, eok, efl;
    int ep, n;
    bit seen;
    @(negedge clk);
    wait_ready();
    insert_val  = ins;
    look_up_val = look;
    ip_addr     = addr;
    model_op(ins, addr, ef, eok, efl, ep);
    @(posedge clk);
    #1;
    insert_val  = 1'b0;
    look_up_val = 1'b0;
    ip_addr     = $urandom;
    checkOutput("busy", 32'(ready), 0);
    seen = 1'b0;
    n = 0;
    while (!seen && n < MAX_PROBE + 4) begin
      @(posedge clk);
      #1;
      n++;
      seen = found_ip_valid;
    end
    checkOutput("latency", seen ? n : 999, ep);
    checkOutput("found_ip", 32'(found_ip), 32'(ef));
    checkOutput("insert_ok", 32'(insert_ok), 32'(eok));
    checkOutput("insert_fail", 32'(insert_fail), 32'(efl));
    checkOutput("entry_count", 32'(entry_count), m_count);
    checkOutput("ready_at_result", 32'(ready), 1);
    @(posedge clk);
    #1;
    checkOutput("pulse_end", 32'({found_ip_valid, found_ip, insert_ok, insert_fail}), 0);
  endtask

  task automatic do_flush();
    @(negedge clk);
    wait_ready();
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    model_reset();
    checkOutput("flush_count", 32'(entry_count), 0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    bit ins, look;
    int r;
    logic [31:0] addr;

    model_reset();
    for (int k = 0; k < 5; k++) wrap_addr[k] = 32'(62 | (k << 6) | (k << 12));

    #12;
    checkOutput("reset_ready", 32'(ready), 1);
    checkOutput("reset_outputs", 32'({found_ip_valid, found_ip, insert_ok, insert_fail}), 0);
    checkOutput("reset_count", 32'(entry_count), 0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(1'b0, 1'b1, 32'h0A00_0001);
    applyStimulus(1'b1, 1'b0, 32'h0A00_0001);
    applyStimulus(1'b0, 1'b1, 32'h0A00_0001);
    applyStimulus(1'b1, 1'b0, 32'h0000_000B);
    applyStimulus(1'b0, 1'b1, 32'h0000_000B);
    applyStimulus(1'b1, 1'b0, 32'h0000_000B);

    do_flush();
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 1'b0, wrap_addr[k]);
    applyStimulus(1'b1, 1'b1, 32'h0A00_000B);
    applyStimulus(1'b0, 1'b1, 32'h0A00_000B);
    do_flush();
    applyStimulus(1'b0, 1'b1, 32'h0A00_000B);

    // Refill the slot-62 chain so the next lookup runs the full window, then reset mid-probe.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 1'b0, wrap_addr[k]);
    @(negedge clk);
    wait_ready();
    look_up_val = 1'b1;
    ip_addr     = wrap_addr[4];
    @(posedge clk);
    #1;
    look_up_val = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_outputs", 32'({found_ip_valid, found_ip, insert_ok, insert_fail}), 0);
    checkOutput("rst_mid_count", 32'(entry_count), 0);
    checkOutput("rst_mid_ready", 32'(ready), 1);
    r = 0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (found_ip_valid) r++;
    end
    checkOutput("rst_no_pulse", r, 0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    checkOutput("post_rst_ready", 32'(ready), 1);
    checkOutput("post_rst_count", 32'(entry_count), 0);
    checkOutput("post_rst_valid", 32'(found_ip_valid), 0);

    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        do_flush();
      end else begin
        ins  = (r < 10);
        look = (r >= 10) || ($urandom_range(0, 3) == 0);
        addr = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
        applyStimulus(ins, look, addr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ip_hash_table.md
Name: ip_hash_table

Overview:
- Storage and probe engine on the slave side of ip_hash_if: inserts IPv4 source addresses and answers membership lookups for the parser's hash controller.
- Open-addressed table with linear probing: valid bits plus address tags in flops.
- Examines one slot per clock.
- No delete operation; synchronous flush only.

Parameters:
- IP_ADDR_W, 32, address width.
- TABLE_DEPTH, 64, number of slots; power of two, at least 4.
- MAX_PROBE, 4, maximum slots examined per operation; range 1..TABLE_DEPTH.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- insert_val  in  1  insert request, sampled only when ready=1
- look_up_val  in  1  lookup request, sampled only when ready=1
- ip_addr  in  IP_ADDR_W  address for the request
- flush  in  1  clear all entries; sampled only when ready=1
- ready  out  1  engine idle, can accept a request
- found_ip  out  1  address present (lookup hit, or insert of an existing entry)
- found_ip_valid  out  1  one-cycle pulse qualifying found_ip, insert_ok, insert_fail
- insert_ok  out  1  insert result: new entry written
- insert_fail  out  1  insert result: probe window exhausted, nothing written
- entry_count  out  $clog2(TABLE_DEPTH)+1  number of valid entries

Behaviour:
- Reset (async, rst_n=0):
  - all valid bits cleared, entry_count=0, FSM=IDLE, ready=1.
  - found_ip, found_ip_valid, insert_ok and insert_fail all 0.
  - Tags are not reset.
  - Reset mid-probe aborts the operation with no result pulse.
- Hash: XOR-fold of ip_addr, zero-padded to a multiple of IDX_W=$clog2(TABLE_DEPTH), in IDX_W-bit chunks.
  - Probe p (p=0..MAX_PROBE-1) addresses slot (hash+p) mod TABLE_DEPTH; wraps past the last slot to slot 0.
- FSM states: IDLE, PROBE.
- IDLE: on a clock edge with ready=1:
  - flush=1: clear all valid bits, set entry_count=0, stay in IDLE. flush has priority over any request.
  - Else insert_val=1: latch ip_addr, op=INSERT, p=0, go to PROBE. insert_val has priority over look_up_val when both are high; the lookup is dropped.
  - Else look_up_val=1: same as insert, with op=LOOKUP.
- PROBE: evaluate slot s=(hash+p) each cycle.
  - Valid and tag==latched ip: found_ip=1. No write, even for an insert.
  - Empty slot, op=LOOKUP: found_ip=0.
  - Empty slot, op=INSERT: write the tag, set the valid bit, entry_count+1, insert_ok=1.
  - Otherwise, if p==MAX_PROBE-1: found_ip=0; for op=INSERT also insert_fail=1.
  - Otherwise: p+1, stay in PROBE.
  - Any terminating outcome returns the FSM to IDLE.
- Result timing:
  - All result outputs are registered; found_ip_valid pulses high for exactly one cycle, in the cycle after the deciding probe.
  - Request sampled at edge E0, decision at probe k (0-based) → found_ip_valid high in the cycle following edge E0+k+1.
  - A first-slot hit gives found_ip_valid in the 2nd cycle after the request cycle.
- ready:
  - ready = (state==IDLE), so it is low throughout PROBE.
  - ready is high in the same cycle as found_ip_valid, allowing back-to-back requests.
  - The hash controller holds requests until ready=1; requests while ready=0 are ignored.
- insert_ok and insert_fail are 0 for lookups.
- found_ip, insert_ok and insert_fail are 0 whenever found_ip_valid=0.
- entry_count never exceeds TABLE_DEPTH.
- A table-full insert ends as insert_fail after MAX_PROBE probes; it never hangs.

Decomposition:
- Package ip_hash_pkg holds:
  - state enum {IDLE, PROBE}
  - op enum {OP_INSERT, OP_LOOKUP}
  - IDX_W helper
  - XOR-fold hash function
- Sub-module ip_hash_fn: combinational fold, parameterised by IP_ADDR_W and IDX_W. Instantiated once, on the input address registered at accept.

Test Plan:
- Reset, then lookup 0x0A000001 (hash 11) → found_ip_valid in 2nd cycle after request, found_ip=0, entry_count=0.
- Insert 0x0A000001 → insert_ok=1 after 1 probe, entry_count=1. Then lookup 0x0A000001 → found_ip=1 after 1 probe.
- Collision: insert 0x0000000B (hash 11, after the previous insert) → insert_ok on probe 1 (slot 12). Then lookup 0x0000000B → found_ip=1, valid 3 cycles after request. Re-insert 0x0000000B → found_ip=1, insert_ok=0, entry_count unchanged at 2.
- Wrap: insert 4 addresses hashing to slot 62 → slots 62, 63, 0, 1 filled. A 5th → insert_fail=1 after 4 probes, entry_count=4.
- Simultaneous insert_val and look_up_val with 0x0A00000B → treated as insert, insert_ok=1. Flush → entry_count=0, subsequent lookup found_ip=0.
- Deassert rst_n during the 3rd probe → all outputs 0 immediately, no result pulse. After release, ready=1 and entry_count=0.
